// File: rtl/cache_mem_backing_pkg.sv
`default_nettype none
// ============================================================================
// Module : cache_mem_backing_pkg
// Brief  : Shared types and constants for the main-memory backing stage.
//          Provides the FSM state encoding, the default init pattern, the
//          statistics counter width and a saturating-increment helper.
// Rev    : 1.0  initial release
// ============================================================================
package cache_mem_backing_pkg;

  // Explicit encodings so waveforms and any external decode stay stable.
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [10:0] c_INIT_XOR_DEFAULT = 11'h2A5;
  localparam int          c_STAT_W           = 16;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [c_STAT_W-1:0] sat_inc(input logic [c_STAT_W-1:0] v);
    return (&v) ? v : v + c_STAT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_mem_backing_mem_array_sp.sv
`default_nettype none
// ============================================================================
// Module : mem_array_sp
// Brief  : Single-port synchronous RAM, no reset on contents or read data.
//          Ports: clk, en (access strobe), we (1=write), addr, wdata,
//          rdata (registered; updates only on an enabled read).
// Rev    : 1.0  initial release
// ============================================================================
module mem_array_sp #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // rdata only moves on a read so it stays valid for the whole response.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        r_mem[addr] <= wdata;
      end else begin
        r_rdata <= r_mem[addr];
      end
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cache_mem_backing.sv
`default_nettype none
// ============================================================================
// Module : cache_mem_backing
// Brief  : Main-memory stage below the L2. After reset it sweeps
//          mem[a] = a ^ INIT_XOR into the array, then serves one read or
//          write at a time over valid/ready, answering LATENCY cycles after
//          acceptance and holding the response until it is taken.
// Ports  : clk, rst (async, active-high)
//          req_valid/req_ready/req_we/req_addr/req_wdata  - request channel
//          resp_valid/resp_ready/resp_we/resp_addr/resp_data - response
//          init_done - init sweep finished
//          stat_rd_cnt/stat_wr_cnt/stat_stall_cnt - only with MEM_STATS_EN
// Macro  : MEM_STATS_EN adds saturating read/write/stall counters.
// Rev    : 1.0  initial release
// ============================================================================
module cache_mem_backing
  import cache_mem_backing_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 11,
  parameter int                    DATA_WIDTH = 11,
  parameter int                    LATENCY    = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_XOR   = DATA_WIDTH'(c_INIT_XOR_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_we,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [DATA_WIDTH-1:0] resp_data,
`ifdef MEM_STATS_EN
  output logic [c_STAT_W-1:0]   stat_rd_cnt,
  output logic [c_STAT_W-1:0]   stat_wr_cnt,
  output logic [c_STAT_W-1:0]   stat_stall_cnt,
`endif
  output logic                  init_done
);

  // Counter holds LATENCY-1 down to 0; zero in BUSY means "enter RESP next".
  localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [c_CNT_W-1:0]    r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_accept;
  logic                  w_mem_en;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_accept = (r_state == ST_IDLE) && req_valid;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_mem_en     = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = r_addr;
    w_mem_wdata  = r_wdata;
    case (r_state)
      ST_INIT: begin
        w_mem_en    = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_ptr;
        w_mem_wdata = DATA_WIDTH'(r_ptr) ^ INIT_XOR;
        if (&r_ptr) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_valid) w_state_next = ST_BUSY;
      end
      ST_BUSY: begin
        // The array is touched on the same edge that moves to RESP, so a
        // read result lands exactly as resp_valid rises.
        if (r_cnt == '0) begin
          w_mem_en     = 1'b1;
          w_mem_we     = r_we;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_INIT;
    endcase
  end

  // ------------------------------------------ sweep pointer and request latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      if (r_state == ST_INIT) begin
        r_ptr <= r_ptr + ADDR_WIDTH'(1);
      end
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= c_CNT_W'(LATENCY - 1);
      end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
      end
    end
  end

  mem_array_sp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .en    (w_mem_en),
    .we    (w_mem_we),
    .addr  (w_mem_addr),
    .wdata (w_mem_wdata),
    .rdata (w_rdata)
  );

  // ------------------------------------------------------------ outputs
  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign init_done  = (r_state != ST_INIT);
  assign resp_we    = r_we;
  assign resp_addr  = r_addr;
  // RAM output carries no reset, so gate it to keep resp_data at 0 outside RESP.
  assign resp_data  = (r_state == ST_RESP) ? (r_we ? r_wdata : w_rdata) : '0;

`ifdef MEM_STATS_EN
  logic [c_STAT_W-1:0] r_stat_rd;
  logic [c_STAT_W-1:0] r_stat_wr;
  logic [c_STAT_W-1:0] r_stat_stall;

  // Acceptance and stalls only occur in IDLE/RESP, so INIT is excluded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_rd    <= '0;
      r_stat_wr    <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_accept && !req_we) r_stat_rd <= sat_inc(r_stat_rd);
      if (w_accept &&  req_we) r_stat_wr <= sat_inc(r_stat_wr);
      if (resp_valid && !resp_ready) r_stat_stall <= sat_inc(r_stat_stall);
    end
  end

  assign stat_rd_cnt    = r_stat_rd;
  assign stat_wr_cnt    = r_stat_wr;
  assign stat_stall_cnt = r_stat_stall;
`endif

endmodule
`default_nettype wire
